// File: rtl/rv32_mdu_seq_if.sv
// Request/response bundle between the execute stage and the iterative M-extension unit.
// The core drives the request side (master); the sequencer answers (slave).
interface rv32_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output busy, done, result
  );
endinterface

// File: rtl/rv32_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider
// sharing one 64-bit working register, one operand register and a 5-bit iteration counter.
module rv32_mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  rv32_mdu_seq_if.slave      io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [2:0]      op;
  logic [63:0]     work;
  logic [XLEN-1:0] opnd;
  logic [4:0]      cnt;
  logic            neg_res;
  logic            neg_rem;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [32:0]     mul_sum;
  logic [32:0]     div_sh, div_diff;
  logic [63:0]     work_step;
  logic [63:0]     prod;
  logic [XLEN-1:0] quo, rem, fix_val;

  // Operand conditioning at accept time: signedness, magnitudes and the special cases.
  always_comb begin
    a_sgn       = (io.funct3 == 3'b000) || (io.funct3 == 3'b001) || (io.funct3 == 3'b010) ||
                  (io.funct3 == 3'b100) || (io.funct3 == 3'b110);
    b_sgn       = (io.funct3 == 3'b000) || (io.funct3 == 3'b001) ||
                  (io.funct3 == 3'b100) || (io.funct3 == 3'b110);
    a_neg       = a_sgn & io.rs1_val[XLEN-1];
    b_neg       = b_sgn & io.rs2_val[XLEN-1];
    a_mag       = a_neg ? (~io.rs1_val + 1'b1) : io.rs1_val;
    b_mag       = b_neg ? (~io.rs2_val + 1'b1) : io.rs2_val;
    special     = 1'b0;
    special_val = '0;
    if (io.funct3[2] && (io.rs2_val == '0)) begin
      special     = 1'b1;
      special_val = io.funct3[1] ? io.rs1_val : 32'hFFFF_FFFF;
    end else if (io.funct3[2] && !io.funct3[0] &&
                 (io.rs1_val == 32'h8000_0000) && (io.rs2_val == 32'hFFFF_FFFF)) begin
      special     = 1'b1;
      special_val = io.funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // One iteration of either datapath; the divider keeps a 33-bit partial remainder.
  always_comb begin
    mul_sum  = {1'b0, work[63:32]} + {1'b0, (work[0] ? opnd : {XLEN{1'b0}})};
    div_sh   = {work[63:32], work[31]};
    div_diff = div_sh - {1'b0, opnd};
    if (op[2]) begin
      if (div_diff[32])
        work_step = {div_sh[31:0], work[30:0], 1'b0};
      else
        work_step = {div_diff[31:0], work[30:0], 1'b1};
    end else begin
      work_step = {mul_sum, work[31:1]};
    end
  end

  // Sign correction and result selection applied in the FIX cycle.
  always_comb begin
    prod = neg_res ? (~work + 64'd1) : work;
    quo  = neg_res ? (~work[31:0] + 1'b1) : work[31:0];
    rem  = neg_rem ? (~work[63:32] + 1'b1) : work[63:32];
    case (op)
      3'b000:                 fix_val = prod[31:0];
      3'b001, 3'b010, 3'b011: fix_val = prod[63:32];
      3'b100, 3'b101:         fix_val = quo;
      default:                fix_val = rem;
    endcase
  end

  // Next-state logic; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_n = state;
    accept  = ((state == IDLE) || (state == DONE)) && io.start && !io.flush;
    case (state)
      IDLE: if (accept) state_n = special ? DONE : CALC;
      CALC: if (cnt == 5'd31) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = accept ? (special ? DONE : CALC) : IDLE;
      default: state_n = IDLE;
    endcase
    if (io.flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == CALC) || (state_n == FIX);
      done_q <= (state_n == DONE);
      if (!io.flush) begin
        if (state == FIX)
          result_q <= fix_val;
        else if (accept && special)
          result_q <= special_val;
      end
    end
  end

  // Multiply loads the multiplier into the low half; divide loads the dividend there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= 3'b000;
      work    <= '0;
      opnd    <= '0;
      cnt     <= 5'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      op      <= io.funct3;
      cnt     <= 5'd0;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (io.funct3[2]) begin
        work <= {32'h0, a_mag};
        opnd <= b_mag;
      end else begin
        work <= {32'h0, b_mag};
        opnd <= a_mag;
      end
    end else if (state == CALC) begin
      cnt  <= cnt + 5'd1;
      work <= work_step;
    end
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = result_q;

endmodule
